// File: rtl/vga_sprite_engine.sv
// VGA timing generator compositing N_SPR shadowed solid rectangles over BG_COLOR; VGA_ENGINE_COLLISION_EN adds the sprite-0 overlap flag.
// Latency: RGB/hsync/vsync/blank lag the pixel counters by 2 pixel ticks and stay mutually aligned.
// Backpressure: wr_ready drops only in the single clk that commits shadow -> live at vblank start.
module vga_sprite_engine #(
  parameter int          N_SPR    = 5,
  parameter int          CLK_DIV  = 2,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [23:0] BG_COLOR = 24'h70C5CE,
  localparam int         IDX_W    = $clog2(N_SPR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic signed [10:0] wr_x,
  input  logic signed [10:0] wr_y,
  input  logic [9:0]         wr_w,
  input  logic [9:0]         wr_h,
  input  logic [23:0]        wr_color,
  input  logic               wr_vis,
  output logic               frame_start,
  output logic               collision,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               sync,
  output logic               vga_clk,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic               vis;
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic [9:0]         w;
    logic [9:0]         h;
    logic [23:0]        color;
  } spr_t;

  function automatic logic signed [11:0] sext(input logic signed [10:0] v);
    return {v[10], v};
  endfunction

  function automatic logic signed [11:0] zext(input logic [9:0] v);
    return {2'b00, v};
  endfunction

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             pix_en, commit;
  logic [11:0]      h_cnt, v_cnt;

  assign pix_en  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign div_nxt = pix_en ? '0 : div_cnt + 1'b1;

  // vga_clk is high for the first half of each pixel period, so it rises right after pix_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      vga_clk <= (int'(div_nxt) < CLK_DIV / 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign commit      = pix_en && (h_cnt == '0) && (v_cnt == V_ACT);
  assign wr_ready    = ~commit;
  assign frame_start = commit;
  assign sync        = 1'b0;

  spr_t shadow [N_SPR];
  spr_t live   [N_SPR];
  spr_t wr_spr;

  assign wr_spr = '{vis: wr_vis, x: wr_x, y: wr_y, w: wr_w, h: wr_h, color: wr_color};

  // Out-of-range indices complete the handshake but are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      if (wr_valid && wr_ready && (int'(wr_idx) < N_SPR))
        shadow[wr_idx] <= wr_spr;
      if (commit)
        for (int i = 0; i < N_SPR; i++) live[i] <= shadow[i];
    end
  end

  logic signed [11:0] px, py;
  logic [N_SPR-1:0]   hit;
  logic               active, hs_n, vs_n;

  assign px     = h_cnt;
  assign py     = v_cnt;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  // Half-open extents: zero width/height can never satisfy px < x + w
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPR; i++)
      hit[i] = live[i].vis
            && (px >= sext(live[i].x)) && (px < sext(live[i].x) + zext(live[i].w))
            && (py >= sext(live[i].y)) && (py < sext(live[i].y) + zext(live[i].h));
  end

  logic [N_SPR-1:0] s1_hit;
  logic             s1_act, s1_hs, s1_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit <= '0;
      s1_act <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
    end else if (pix_en) begin
      s1_hit <= hit;
      s1_act <= active;
      s1_hs  <= hs_n;
      s1_vs  <= vs_n;
    end
  end

  logic [23:0] pick, rgb;

  always_comb begin
    pick = BG_COLOR;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (s1_hit[i]) pick = live[i].color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b0;
    end else if (pix_en) begin
      rgb   <= s1_act ? pick : '0;
      hsync <= s1_hs;
      vsync <= s1_vs;
      blank <= s1_act;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;

`ifdef VGA_ENGINE_COLLISION_EN
  logic coll_flag;

  // Commit lands in vertical blank, so it never races an active-pixel set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_flag <= 1'b0;
      collision <= 1'b0;
    end else if (commit) begin
      collision <= coll_flag;
      coll_flag <= 1'b0;
    end else if (pix_en && active && hit[0] && (|hit[N_SPR-1:1])) begin
      coll_flag <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a reduced raster; pixel expectations are queued per frame and checked as pixels emerge.
module tb_vga_sprite_engine;
  localparam int CD = 2;
  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;
  localparam logic [23:0] BG = 24'h70C5CE;

  logic               clk, rst, wr_valid, wr_ready, wr_vis;
  logic [2:0]         wr_idx;
  logic signed [10:0] wr_x, wr_y;
  logic [9:0]         wr_w, wr_h;
  logic [23:0]        wr_color;
  logic               frame_start, collision, hsync, vsync, blank, sync, vga_clk;
  logic [7:0]         vga_r, vga_g, vga_b;

  vga_sprite_engine #(
    .N_SPR(5), .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h),
    .wr_color(wr_color), .wr_vis(wr_vis),
    .frame_start(frame_start), .collision(collision),
    .hsync(hsync), .vsync(vsync), .blank(blank), .sync(sync),
    .vga_clk(vga_clk), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int f; int x; int y; logic [23:0] c; } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cur_frame = 0;

  // Output-side raster tracker: pixel position is inferred only from blank/vsync/vga_clk
  initial begin
    int ox, oy;
    logic pv, pb;
    ox = 0; oy = 0; pv = 1'b0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ox = 0; oy = 0; pv = 1'b0; pb = 1'b0;
      end else begin
        if (frame_start) cur_frame++;
        if (vga_clk && !pv) begin
          if (blank) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
              if (sb[i].f == cur_frame && sb[i].x == ox && sb[i].y == oy) begin
                n_tests++;
                if ({vga_r, vga_g, vga_b} !== sb[i].c) begin
                  n_fail++;
                  $display("FAIL pixel(%0d,%0d)@frame%0d: got %h, expected %h",
                           ox, oy, cur_frame, {vga_r, vga_g, vga_b}, sb[i].c);
                end
                sb.delete(i);
              end
            end
            ox++;
          end else if (pb) begin
            ox = 0;
            oy++;
          end
          if (!vsync) oy = 0;
          pb = blank;
        end
        pv = vga_clk;
      end
    end
  end

  task automatic expect_px(input int f, input int x, input int y, input logic [23:0] c);
    exp_t e;
    e.f = f; e.x = x; e.y = y; e.c = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 4 * FRAME) begin
      @(posedge clk);
      k++;
    end
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL pixel(%0d,%0d)@frame%0d: never observed, expected %h", sb[i].x, sb[i].y, sb[i].f, sb[i].c);
    end
    sb.delete();
    #1;
  endtask

  task automatic wait_commit();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 2 * FRAME);
    if (!frame_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_commit: no frame_start within %0d clk", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input int x, input int y, input int w, input int h,
                          input logic [23:0] c, input logic vis);
    int k = 0;
    wr_idx = 3'(idx); wr_x = 11'(x); wr_y = 11'(y); wr_w = 10'(w); wr_h = 10'(h);
    wr_color = c; wr_vis = vis; wr_valid = 1'b1;
    @(negedge clk);
    while (!wr_ready && k < 4) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({hsync, vsync, blank, sync, vga_clk, frame_start, collision, wr_ready} !== 8'b1100_0001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 11000001",
               {hsync, vsync, blank, sync, vga_clk, frame_start, collision, wr_ready});
    end
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h, expected 000000", {vga_r, vga_g, vga_b});
    end
    expect_px(0, 0, 0, BG);
    expect_px(0, HA - 1, VA - 1, BG);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_timing();
    int c = 0, hs_low = 0, vs_low = 0, bl_hi = 0, bad_rgb = 0, vrise = 0;
    int run = 0, run_min = 1 << 30, run_max = 0, last_fall = -1, per_min = 1 << 30, per_max = 0;
    logic phs = 1'b1, pvc = 1'b0;
    wait_commit();
    do begin
      @(negedge clk);
      c++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (blank) bl_hi++;
      if (!blank && {vga_r, vga_g, vga_b} != 24'h0) bad_rgb++;
      if (vga_clk && !pvc) vrise++;
      if (!hsync) run++;
      else if (run > 0) begin
        if (run < run_min) run_min = run;
        if (run > run_max) run_max = run;
        run = 0;
      end
      if (!hsync && phs) begin
        if (last_fall >= 0) begin
          if (c - last_fall < per_min) per_min = c - last_fall;
          if (c - last_fall > per_max) per_max = c - last_fall;
        end
        last_fall = c;
      end
      phs = hsync;
      pvc = vga_clk;
    end while (!frame_start && c < 2 * FRAME);
    n_tests++;
    if (c !== FRAME) begin n_fail++; $display("FAIL frame_period: got %0d clk, expected %0d", c, FRAME); end
    n_tests++;
    if (hs_low !== VT * HS * CD) begin n_fail++; $display("FAIL hsync_low_total: got %0d, expected %0d", hs_low, VT * HS * CD); end
    n_tests++;
    if (run_min !== HS * CD || run_max !== HS * CD) begin
      n_fail++; $display("FAIL hsync_width: got %0d..%0d, expected %0d", run_min, run_max, HS * CD);
    end
    n_tests++;
    if (per_min !== HT * CD || per_max !== HT * CD) begin
      n_fail++; $display("FAIL hsync_period: got %0d..%0d, expected %0d", per_min, per_max, HT * CD);
    end
    n_tests++;
    if (vs_low !== VS * HT * CD) begin n_fail++; $display("FAIL vsync_low: got %0d, expected %0d", vs_low, VS * HT * CD); end
    n_tests++;
    if (bl_hi !== HA * VA * CD) begin n_fail++; $display("FAIL blank_high: got %0d, expected %0d", bl_hi, HA * VA * CD); end
    n_tests++;
    if (bad_rgb !== 0) begin n_fail++; $display("FAIL rgb_in_blank: got %0d nonzero clk, expected 0", bad_rgb); end
    n_tests++;
    if (vrise !== HT * VT) begin n_fail++; $display("FAIL vga_clk_rises: got %0d, expected %0d", vrise, HT * VT); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_shadow();
    int f;
    wait_commit();
    f = cur_frame;
    do_write(1, 10, 5, 6, 4, 24'hFF0000, 1'b1);
    expect_px(f, 10, 5, BG);
    expect_px(f + 1, 10, 5, 24'hFF0000);
    expect_px(f + 1, 15, 8, 24'hFF0000);
    expect_px(f + 1, 16, 8, BG);
    expect_px(f + 1, 10, 9, BG);
    drain();
  endtask

  task automatic test_priority();
    int f;
    wait_commit();
    f = cur_frame;
    do_write(2, 20, 20, 4, 3, 24'h0000FF, 1'b1);
    do_write(0, 20, 20, 3, 3, 24'h00FF00, 1'b1);
    expect_px(f + 1, 20, 20, 24'h00FF00);
    expect_px(f + 1, 22, 22, 24'h00FF00);
    expect_px(f + 1, 23, 20, 24'h0000FF);
    expect_px(f + 1, 24, 20, BG);
    drain();
  endtask

  task automatic test_clip();
    int f;
    wait_commit();
    f = cur_frame;
    do_write(3, -32, 0, 34, 2, 24'hFFFF00, 1'b1);
    do_write(7, 30, 10, 4, 4, 24'hFF00FF, 1'b1);
    expect_px(f + 1, 0, 0, 24'hFFFF00);
    expect_px(f + 1, 1, 1, 24'hFFFF00);
    expect_px(f + 1, 2, 0, BG);
    expect_px(f + 1, 30, 10, BG);
    expect_px(f + 1, 31, 11, BG);
    drain();
  endtask

  task automatic test_handshake();
    int k = 0, low = 0, skew = 0, post = 0;
    logic [23:0] want = 24'h0;
    logic seen = 1'b0;
    wr_idx = 3'd4; wr_x = 11'sd35; wr_y = 11'sd10; wr_w = 10'd2; wr_h = 10'd2; wr_vis = 1'b1;
    wr_valid = 1'b1;
    while (post < 4 && k < 2 * FRAME) begin
      wr_color = 24'h100000 + 24'(k);
      @(negedge clk);
      if (!wr_ready) low++;
      if (wr_ready === frame_start) skew++;
      if (frame_start && !seen) begin
        seen = 1'b1;
        want = 24'h100000 + 24'(k - 1);
      end else if (seen) begin
        post++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    wr_valid = 1'b0;
    n_tests++;
    if (!seen || low !== 1) begin n_fail++; $display("FAIL commit_ready_low: got %0d clk, expected 1", low); end
    n_tests++;
    if (skew !== 0) begin n_fail++; $display("FAIL ready_vs_frame_start: got %0d misaligned clk, expected 0", skew); end
    expect_px(cur_frame, 35, 10, want);
    expect_px(cur_frame, 36, 11, want);
    drain();
  endtask

  task automatic test_collision();
`ifdef VGA_ENGINE_COLLISION_EN
    int f;
    wait_commit();
    do_write(2, 20, 20, 4, 3, 24'h0000FF, 1'b0);
    do_write(0, 5, 25, 3, 3, 24'h00FF00, 1'b1);
    do_write(3, 6, 26, 3, 3, 24'hFFFF00, 1'b1);
    wait_commit();
    f = cur_frame;
    n_tests++;
    if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_prev_overlap: got %b, expected 1", collision); end
    do_write(3, 30, 28, 2, 2, 24'hFFFF00, 1'b1);
    expect_px(f, 6, 26, 24'h00FF00);
    expect_px(f, 8, 28, 24'hFFFF00);
    wait_commit();
    n_tests++;
    if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_set: got %b, expected 1", collision); end
    repeat (FRAME / 2) @(posedge clk);
    #1;
    n_tests++;
    if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_hold: got %b, expected 1", collision); end
    wait_commit();
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL collision_clear: got %b, expected 0", collision); end
    drain();
`else
    wait_commit();
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL collision_tied: got %b, expected 0", collision); end
    repeat (FRAME / 2) @(posedge clk);
    #1;
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL collision_tied_mid: got %b, expected 0", collision); end
`endif
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!blank && k < 2 * FRAME);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({hsync, vsync, blank, sync, vga_clk, frame_start, collision, wr_ready} !== 8'b1100_0001) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got %b, expected 11000001",
               {hsync, vsync, blank, sync, vga_clk, frame_start, collision, wr_ready});
    end
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL midreset_rgb: got %h, expected 000000", {vga_r, vga_g, vga_b});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 2 * FRAME);
    n_tests++;
    if (k !== 2 * (VA * HT + 1)) begin
      n_fail++;
      $display("FAIL restart_commit_delay: got %0d clk, expected %0d", k, 2 * (VA * HT + 1));
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0;
    wr_w = '0; wr_h = '0; wr_color = '0; wr_vis = 1'b0;
    test_reset();
    test_timing();
    test_shadow();
    test_priority();
    test_clip();
    test_handshake();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
